sdp_mem_bridge: RTL



---
 rtl/sdp_mem_bridge.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sdp_mem_bridge.sv
// sdp_mem_bridge: one-wire serial debug port to core memory bridge.
// Decodes RD/WR/RDINC command frames, issues memory requests and returns ack/data frames.
package sdp_mem_pkg;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_STRB_W = MEM_DATA_W / 8;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_type_e;

    typedef struct packed {
        mem_type_e             req_type;
        logic [MEM_ADDR_W-1:0] req_addr;
        logic [MEM_STRB_W-1:0] req_mask;
        logic [MEM_DATA_W-1:0] req_data;
        logic                  req_burst;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] resp_data;
    } mem_resp_t;
endpackage

module sdp_mem_bridge
    import sdp_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int LEN_W  = 4,
    parameter int TO_W   = 8
) (
    input  logic      sdp_ck,
    input  logic      sdp_rstn,
    input  logic      sdp_di,
    output logic      sdp_do,
    output logic      sdp_doen,
    output logic      sdp_irq,
    output logic      mem_req_valid,
    input  logic      mem_req_ready,
    output mem_req_t  mem_req,
    input  logic      mem_resp_valid,
    output logic      mem_resp_ready,
    input  mem_resp_t mem_resp
);

    localparam int STRB_W = DATA_W / 8;
    localparam int HDR_N  = 2 + LEN_W + ADDR_W;
    localparam int WD_N   = STRB_W + DATA_W;
    localparam int CNT_W  = $clog2(HDR_N + WD_N + 1);
    localparam int TXW    = DATA_W + 4;
    localparam int TXC_W  = $clog2(TXW);

    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(HDR_N);
    localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(HDR_N + WD_N);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'((2 ** TO_W) - 2);
    localparam logic [TXC_W-1:0] TXC_RD  = TXC_W'(TXW - 1);
    localparam logic [TXC_W-1:0] TXC_SH  = TXC_W'(3);
    localparam logic [1:0]       CMD_WR  = 2'b01;
    localparam logic [1:0]       CMD_INC = 2'b10;
    localparam logic [1:0]       CMD_RSV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_CHECK,
        S_REQ,
        S_RSP,
        S_TX,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic               di_prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               par_q, par_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic               stale_q, stale_d;
    logic               irq_q, irq_d;

    logic [HDR_N-1:0]   hdr_q, hdr_d;
    logic [WD_N-1:0]    wd_q, wd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [TXW-1:0]     tx_sh_q, tx_sh_d;

    logic [1:0]         cmd_w;
    logic               is_wr;

    assign cmd_w = hdr_q[HDR_N-1 -: 2];
    assign is_wr = (cmd_w == CMD_WR);

    function automatic logic [TXW-1:0] read_frame(input logic ack, input logic [DATA_W-1:0] data);
        return {1'b0, ack, data, ^{ack, data}, 1'b1};
    endfunction

    // Short frames sit in the top four bits; the shifter fills behind them with idle ones.
    function automatic logic [TXW-1:0] short_frame(input logic ack);
        return {1'b0, ack, ack, 1'b1, {DATA_W{1'b1}}};
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        beats_d  = beats_q;
        to_d     = to_q;
        tx_cnt_d = tx_cnt_q;
        stale_d  = stale_q;
        irq_d    = 1'b0;
        hdr_d    = hdr_q;
        wd_d     = wd_q;
        addr_d   = addr_q;
        tx_sh_d  = tx_sh_q;

        if (stale_q && mem_resp_valid) begin
            stale_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (di_prev_q && !sdp_di) begin
                    state_d = S_RX;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            S_RX: begin
                par_d = par_q ^ sdp_di;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q < LAST_RD) begin
                    hdr_d = {hdr_q[HDR_N-2:0], sdp_di};
                end else if (cnt_q < LAST_WR) begin
                    wd_d = {wd_q[WD_N-2:0], sdp_di};
                end
                if ((is_wr && cnt_q == LAST_WR) || (!is_wr && cnt_q == LAST_RD)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                addr_d = hdr_q[ADDR_W-1:0];
                if (par_q || cmd_w == CMD_RSV) begin
                    state_d  = S_TX;
                    tx_sh_d  = short_frame(1'b1);
                    tx_cnt_d = TXC_SH;
                    irq_d    = 1'b1;
                    beats_d  = '0;
                end else begin
                    state_d = S_REQ;
                    beats_d = (cmd_w == CMD_INC) ? hdr_q[ADDR_W +: LEN_W] : '0;
                end
            end
            S_REQ: begin
                if (!stale_q && mem_req_ready) begin
                    state_d = S_RSP;
                    to_d    = '0;
                end
            end
            S_RSP: begin
                // A response in the expiry cycle still wins over the timeout.
                if (mem_resp_valid) begin
                    state_d  = S_TX;
                    tx_sh_d  = is_wr ? short_frame(1'b0) : read_frame(1'b0, mem_resp.resp_data);
                    tx_cnt_d = is_wr ? TXC_SH : TXC_RD;
                end else if (to_q == TO_LAST) begin
                    state_d  = S_TX;
                    tx_sh_d  = is_wr ? short_frame(1'b1) : read_frame(1'b1, '0);
                    tx_cnt_d = is_wr ? TXC_SH : TXC_RD;
                    irq_d    = 1'b1;
                    stale_d  = 1'b1;
                    beats_d  = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_TX: begin
                if (tx_cnt_q == '0) begin
                    state_d = S_GAP;
                end else begin
                    tx_cnt_d = tx_cnt_q - TXC_W'(1);
                    tx_sh_d  = {tx_sh_q[TXW-2:0], 1'b1};
                end
            end
            S_GAP: begin
                if (beats_q != '0) begin
                    state_d = S_REQ;
                    beats_d = beats_q - LEN_W'(1);
                    addr_d  = addr_q + ADDR_W'(STRB_W);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sdp_ck or negedge sdp_rstn) begin
        if (!sdp_rstn) begin
            state_q   <= S_IDLE;
            di_prev_q <= 1'b1;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            beats_q   <= '0;
            to_q      <= '0;
            tx_cnt_q  <= '0;
            stale_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            di_prev_q <= sdp_di;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            beats_q   <= beats_d;
            to_q      <= to_d;
            tx_cnt_q  <= tx_cnt_d;
            stale_q   <= stale_d;
            irq_q     <= irq_d;
        end
    end

    // Datapath registers carry no reset; every consumer is qualified by state.
    always_ff @(posedge sdp_ck) begin
        hdr_q   <= hdr_d;
        wd_q    <= wd_d;
        addr_q  <= addr_d;
        tx_sh_q <= tx_sh_d;
    end

    assign sdp_irq        = irq_q;
    assign sdp_doen       = (state_q != S_TX);
    assign sdp_do         = (state_q == S_TX) ? tx_sh_q[TXW-1] : 1'b1;
    assign mem_req_valid  = (state_q == S_REQ) && !stale_q;
    assign mem_resp_ready = (state_q == S_RSP) || stale_q;

    always_comb begin
        mem_req           = '0;
        mem_req.req_type  = is_wr ? MEM_WRITE : MEM_READ;
        mem_req.req_addr  = addr_q;
        mem_req.req_mask  = is_wr ? wd_q[WD_N-1 -: STRB_W] : {STRB_W{1'b1}};
        mem_req.req_data  = is_wr ? wd_q[DATA_W-1:0] : '0;
        mem_req.req_burst = 1'b1;
    end

endmodule
